// File: rtl/vend_dispenser_pkg.sv
// Shared vending package: FSM state encoding, item/change code constants
// and the change-code to coin-count mapping. Used by the vending FSM and
// by the dispenser that carries out its jobs.
package vend_dispenser_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_VEND     = 3'd1,
    ST_COIN_ON  = 3'd2,
    ST_COIN_OFF = 3'd3,
    ST_DONE     = 3'd4
  } vend_state_e;

  localparam logic [1:0] ITEM_NONE    = 2'b00;
  localparam logic [1:0] ITEM_A       = 2'b01;  // twenty-unit item
  localparam logic [1:0] ITEM_B       = 2'b10;  // fifty-unit item
  localparam logic [1:0] ITEM_ILLEGAL = 2'b11;

  localparam logic [1:0] CHG_NONE   = 2'b00;
  localparam logic [1:0] CHG_TEN    = 2'b01;
  localparam logic [1:0] CHG_THIRTY = 2'b10;
  localparam logic [1:0] CHG_FORTY  = 2'b11;

  // Number of ten-unit coins to eject for a change code.
  function automatic logic [2:0] coin_count(input logic [1:0] chg);
    logic [2:0] n;
    n = 3'd0;
    case (chg)
      CHG_NONE:   n = 3'd0;
      CHG_TEN:    n = 3'd1;
      CHG_THIRTY: n = 3'd3;
      CHG_FORTY:  n = 3'd4;
      default:    n = 3'd0;
    endcase
    return n;
  endfunction

  // True for the two item codes that name a real product.
  function automatic logic item_active(input logic [1:0] it);
    logic a;
    a = 1'b0;
    case (it)
      ITEM_A, ITEM_B:         a = 1'b1;
      ITEM_NONE, ITEM_ILLEGAL: a = 1'b0;
      default:                a = 1'b0;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/vend_pulse_timer.sv
// State-duration down-counter.
// Ports: clk, rst_n (sync, active-low); load/load_val reload the counter,
// dec counts down by one (saturating at zero); zero flags a count of 0.
module vend_pulse_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)                     cnt_d = load_val;
    else if (dec && cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= 4'd0;
    else        cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == 4'd0);

endmodule

// File: rtl/vend_dispenser.sv
// Vend dispenser: runs the item motor for PULSE_LEN cycles, then ejects the
// latched number of ten-unit coins (PULSE_LEN high, GAP_LEN low each), then
// strobes done. All outputs are registered from the current state, so they
// trail the state register by one cycle.
// Handshake: a request is the rising edge of item into 01/10; there is no
// ready signal -- a request arriving while not IDLE is discarded and
// reported by a one-cycle req_drop strobe the following cycle.
// Ports: clk, rst_n (sync, active-low), item[1:0], change[1:0] in;
// motor_a, motor_b, coin_pulse, busy, done, req_drop out;
// dbg_state[2:0] exposes the FSM state.
module vend_dispenser
  import vend_dispenser_pkg::*;
#(
  parameter int PULSE_LEN = 4,
  parameter int GAP_LEN   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] item,
  input  logic [1:0] change,
  output logic       motor_a,
  output logic       motor_b,
  output logic       coin_pulse,
  output logic       busy,
  output logic       done,
  output logic       req_drop,
  output logic [2:0] dbg_state
);

  localparam logic [3:0] PULSE_LOAD = 4'(PULSE_LEN - 1);
  localparam logic [3:0] GAP_LOAD   = 4'(GAP_LEN - 1);

  vend_state_e state_q, state_d;
  logic [1:0]  job_item_q, job_item_d;
  logic [2:0]  count_q, count_d;
  logic        prev_active_q, prev_active_d;
  logic        motor_a_q, motor_a_d, motor_b_q, motor_b_d;
  logic        coin_pulse_q, coin_pulse_d, busy_q, busy_d;
  logic        done_q, done_d, req_drop_q, req_drop_d;
  logic        request, tmr_load, tmr_zero;
  logic [3:0]  tmr_val;

  // Only the transition into an active item code counts as a request.
  assign request       = item_active(item) && !prev_active_q;
  assign prev_active_d = item_active(item);

  vend_pulse_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (1'b1),
    .zero     (tmr_zero)
  );

  // State register (job data and registered outputs ride along).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      job_item_q    <= ITEM_NONE;
      count_q       <= 3'd0;
      prev_active_q <= 1'b1;  // an item held through reset must drop first
      motor_a_q     <= 1'b0;
      motor_b_q     <= 1'b0;
      coin_pulse_q  <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      req_drop_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      job_item_q    <= job_item_d;
      count_q       <= count_d;
      prev_active_q <= prev_active_d;
      motor_a_q     <= motor_a_d;
      motor_b_q     <= motor_b_d;
      coin_pulse_q  <= coin_pulse_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      req_drop_q    <= req_drop_d;
    end
  end

  // Next-state logic; the timer is reloaded on every state change with the
  // duration of the state being entered, minus one.
  always_comb begin
    state_d    = state_q;
    job_item_d = job_item_q;
    count_d    = count_q;
    case (state_q)
      ST_IDLE: begin
        if (request) begin
          state_d    = ST_VEND;
          job_item_d = item;
          count_d    = coin_count(change);
        end
      end
      ST_VEND: begin
        if (tmr_zero) state_d = (count_q != 3'd0) ? ST_COIN_ON : ST_DONE;
      end
      ST_COIN_ON: begin
        if (tmr_zero) begin
          state_d = ST_COIN_OFF;
          count_d = count_q - 3'd1;
        end
      end
      ST_COIN_OFF: begin
        if (tmr_zero) state_d = (count_q != 3'd0) ? ST_COIN_ON : ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    tmr_load = (state_d != state_q);
    tmr_val  = 4'd0;
    case (state_d)
      ST_VEND, ST_COIN_ON: tmr_val = PULSE_LOAD;
      ST_COIN_OFF:         tmr_val = GAP_LOAD;
      default:             tmr_val = 4'd0;
    endcase
  end

  // Output decode, registered one cycle later.
  always_comb begin
    motor_a_d    = (state_q == ST_VEND) && (job_item_q == ITEM_A);
    motor_b_d    = (state_q == ST_VEND) && (job_item_q == ITEM_B);
    coin_pulse_d = (state_q == ST_COIN_ON);
    busy_d       = (state_q != ST_IDLE);
    done_d       = (state_q == ST_DONE);
    req_drop_d   = request && (state_q != ST_IDLE);
  end

  assign motor_a    = motor_a_q;
  assign motor_b    = motor_b_q;
  assign coin_pulse = coin_pulse_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign req_drop   = req_drop_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_vend_dispenser.sv
// Directed bench for vend_dispenser (PULSE_LEN=4, GAP_LEN=2). Cycle k of a
// case is the clock period that starts at edge k; the request is driven in
// cycle -1 so it is sampled at edge 0. Outputs are sampled 1 time unit after
// each rising edge.
module tb_vend_dispenser;
  import vend_dispenser_pkg::*;

  logic       clk, rst_n;
  logic [1:0] item, change;
  logic       motor_a, motor_b, coin_pulse, busy, done, req_drop;
  logic [2:0] dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  vend_dispenser #(.PULSE_LEN(4), .GAP_LEN(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .item       (item),
    .change     (change),
    .motor_a    (motor_a),
    .motor_b    (motor_b),
    .coin_pulse (coin_pulse),
    .busy       (busy),
    .done       (done),
    .req_drop   (req_drop),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    item   = 2'b00;
    change = 2'b00;
    rst_n  = 1'b1;
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic logic in_rng(input int k, input int lo, input int hi);
    return (k >= lo) && (k <= hi);
  endfunction

  // Inputs for case id in cycle k.
  task automatic drive(input int id, input int k);
    item   = 2'b00;
    change = 2'b00;
    rst_n  = 1'b1;
    case (id)
      1: if (k == -1) begin item = 2'b01; change = 2'b10; end
      2: if (k == -1) begin item = 2'b10; change = 2'b00; end
      3: begin
        if (k == -1) begin item = 2'b10; change = 2'b01; end
        if (k == 6)  item = 2'b01;
      end
      4: if (in_rng(k, -1, 8)) item = 2'b01;
      5: begin
        if (in_rng(k, -1, 2)) begin item = 2'b11; change = 2'b11; end
        if (in_rng(k, 3, 5))  begin item = 2'b00; change = 2'b11; end
      end
      6: begin
        change = 2'b11;
        if (in_rng(k, -1, 12) || in_rng(k, 14, 17)) item = 2'b01;
        if (k == 6) rst_n = 1'b0;
      end
      7: begin
        if (k == -1) item = 2'b10;
        if (k == 4)  item = 2'b01;
      end
      default: ;
    endcase
  endtask

  // Hand-derived output traces {motor_a, motor_b, coin_pulse, busy, done, req_drop}.
  function automatic logic [5:0] expv(input int id, input int k);
    logic ma, mb, cp, bz, dn, dr;
    ma = 0; mb = 0; cp = 0; bz = 0; dn = 0; dr = 0;
    case (id)
      1: begin
        ma = in_rng(k, 1, 4);
        cp = in_rng(k, 5, 8) || in_rng(k, 11, 14) || in_rng(k, 17, 20);
        bz = in_rng(k, 1, 23);
        dn = (k == 23);
      end
      2: begin mb = in_rng(k, 1, 4); bz = in_rng(k, 1, 5); dn = (k == 5); end
      3: begin
        mb = in_rng(k, 1, 4); cp = in_rng(k, 5, 8);
        bz = in_rng(k, 1, 11); dn = (k == 11); dr = (k == 7);
      end
      4: begin ma = in_rng(k, 1, 4); bz = in_rng(k, 1, 5); dn = (k == 5); end
      6: begin
        ma = in_rng(k, 1, 4) || in_rng(k, 16, 17);
        cp = in_rng(k, 5, 6);
        bz = in_rng(k, 1, 6) || in_rng(k, 16, 17);
      end
      7: begin
        mb = in_rng(k, 1, 4); bz = in_rng(k, 1, 5);
        dn = (k == 5); dr = (k == 5);
      end
      default: ;
    endcase
    return {ma, mb, cp, bz, dn, dr};
  endfunction

  task automatic run_case(input int id, input int last);
    for (int k = -1; k <= last; k++) begin
      drive(id, k);
      if (k >= 0) begin
        check_eq($sformatf("c%0d_k%0d", id, k),
                 {2'b00, motor_a, motor_b, coin_pulse, busy, done, req_drop},
                 {2'b00, expv(id, k)});
        if (id == 6 && k == 7)
          check_eq("c6_state_after_reset", {5'b0, dbg_state}, {5'b0, ST_IDLE});
      end
      step();
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    item   = 2'b00;
    change = 2'b00;
    step(); step(); step();
    check_eq("reset_outputs", {2'b00, motor_a, motor_b, coin_pulse, busy, done, req_drop}, 8'h00);
    check_eq("reset_state", {5'b0, dbg_state}, {5'b0, ST_IDLE});
    idle(3);

    run_case(1, 26); idle(4);   // item A, three coins
    run_case(2, 8);  idle(4);   // item B, no change
    run_case(3, 14); idle(4);   // request while coining is dropped
    run_case(4, 14); idle(4);   // held item forms one job only
    run_case(5, 8);  idle(4);   // illegal item / change without item
    run_case(6, 17); idle(40);  // reset mid-dispense with item held
    run_case(7, 10); idle(4);   // request in DONE is dropped

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
